// File: rtl/spindle_rate_encoder_pkg.sv
// Shared constants and types for the spindle rate encoder and its float-to-integer front end.
package spindle_rate_encoder_pkg;

  localparam int          FP_BIAS     = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_100K     = 32'h47C3_5000;  // 100000.0
  localparam int          DEF_TICK_HZ = 1000000;
  localparam int          RATE_W      = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REFRACT = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

endpackage

// File: rtl/spindle_rate_encoder_if.sv
// Rate-in / spike-out bundle between a spindle channel and its spike encoder.
interface spindle_rate_encoder_if
  import spindle_rate_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic              enable;
  logic [31:0]       rate_in;
  logic              rate_valid;
  logic              tick_en;
  logic              spike;
  logic [CNT_W-1:0]  spike_count;
  logic [RATE_W-1:0] rate_q;
  logic              sat;
  logic              busy_refract;

  modport master (
    output enable, rate_in, rate_valid, tick_en,
    input  spike, spike_count, rate_q, sat, busy_refract
  );

  modport slave (
    input  enable, rate_in, rate_valid, tick_en,
    output spike, spike_count, rate_q, sat, busy_refract
  );
endinterface

// File: rtl/spindle_rate_encoder_float_to_uint_clamp.sv
// Two-stage IEEE-754 single to unsigned integer converter with clamp and sticky saturation.
module float_to_uint_clamp
  import spindle_rate_encoder_pkg::*;
#(
  parameter int MAX_RATE = 100000,
  parameter int TICK_HZ  = DEF_TICK_HZ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic [RATE_W-1:0] out_val,
  output logic              sat
);

  localparam int LIMIT = (MAX_RATE < TICK_HZ) ? MAX_RATE : TICK_HZ;

  fp32_t             f;
  logic [7:0]        e8;
  logic [4:0]        shamt;
  logic [23:0]       shifted;
  logic [RATE_W-1:0] s1_val_c, s1_val;
  logic              s1_ovf_c, s1_ovf, s1_vld;

  assign f = fp32_t'(in_word);

  always_comb begin
    s1_val_c = '0;
    s1_ovf_c = 1'b0;
    e8       = f.exp - 8'(FP_BIAS);
    shamt    = 5'(8'd23 - e8);
    shifted  = {1'b1, f.man} >> shamt;
    // Negatives (including -inf and negative NaN) and sub-unity values all map to zero.
    if (f.sign) begin
      s1_val_c = '0;
    end else if (f.exp == FP_EXP_MAX) begin
      if (f.man == '0) begin
        s1_val_c = RATE_W'(MAX_RATE);
        s1_ovf_c = 1'b1;
      end
    end else if (f.exp < 8'(FP_BIAS)) begin
      s1_val_c = '0;
    end else if (e8 >= 8'd17) begin
      s1_val_c = RATE_W'(MAX_RATE);
      s1_ovf_c = 1'b1;
    end else begin
      s1_val_c = RATE_W'(shifted);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_val <= '0;
      s1_ovf <= 1'b0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_val <= s1_val_c;
        s1_ovf <= s1_ovf_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val <= '0;
      sat     <= 1'b0;
    end else if (s1_vld) begin
      if (s1_val > RATE_W'(LIMIT)) begin
        out_val <= RATE_W'(LIMIT);
        sat     <= 1'b1;
      end else begin
        out_val <= s1_val;
      end
      if (s1_ovf) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/spindle_rate_encoder.sv
// Integrate-and-fire spike encoder: accumulates the converted rate each tick and fires on threshold.
module spindle_rate_encoder
  import spindle_rate_encoder_pkg::*;
#(
  parameter int TICK_HZ       = DEF_TICK_HZ,
  parameter int MAX_RATE      = 100000,
  parameter int REFRACT_TICKS = 0,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  spindle_rate_encoder_if.slave  bus
);

  localparam int          RC_W   = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;
  localparam logic [31:0] THRESH = 32'(TICK_HZ);

  enc_state_t        state, state_n;
  logic [31:0]       acc, acc_n, acc_sum;
  logic [RC_W-1:0]   rcnt, rcnt_n;
  logic              spike_r, spike_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [RATE_W-1:0] rate_q;

  float_to_uint_clamp #(
    .MAX_RATE (MAX_RATE),
    .TICK_HZ  (TICK_HZ)
  ) u_conv (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.rate_valid),
    .in_word  (bus.rate_in),
    .out_val  (rate_q),
    .sat      (bus.sat)
  );

  assign bus.rate_q       = rate_q;
  assign bus.spike        = spike_r;
  assign bus.spike_count  = cnt;
  assign bus.busy_refract = (state == ST_REFRACT);

  // rate_q never exceeds TICK_HZ and acc stays below it, so the sum cannot wrap.
  assign acc_sum = acc + 32'(rate_q);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    rcnt_n  = rcnt;
    spike_n = 1'b0;
    cnt_n   = cnt;
    if (!bus.enable) begin
      state_n = ST_IDLE;
      acc_n   = '0;
      rcnt_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          acc_n   = '0;
          state_n = ST_RUN;
        end
        ST_RUN: begin
          if (bus.tick_en) begin
            if (acc_sum >= THRESH) begin
              spike_n = 1'b1;
              acc_n   = acc_sum - THRESH;
              cnt_n   = cnt + 1'b1;
              if (REFRACT_TICKS > 0) begin
                state_n = ST_REFRACT;
                rcnt_n  = RC_W'(REFRACT_TICKS);
              end
            end else begin
              acc_n = acc_sum;
            end
          end
        end
        ST_REFRACT: begin
          // Accumulator frozen; the tick that sees a count of one hands back to RUN.
          if (bus.tick_en) begin
            if (rcnt == RC_W'(1)) begin
              state_n = ST_RUN;
              rcnt_n  = '0;
            end else begin
              rcnt_n = rcnt - 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          acc_n   = '0;
          rcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      acc     <= '0;
      rcnt    <= '0;
      spike_r <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      rcnt    <= rcnt_n;
      spike_r <= spike_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_spindle_rate_encoder.sv
// Bench for spindle_rate_encoder: conversion table with scoreboard, plus spike-timing sequences.
module tb_spindle_rate_encoder;
  import spindle_rate_encoder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  spindle_rate_encoder_if #(.CNT_W(16)) if0 ();
  spindle_rate_encoder_if #(.CNT_W(16)) if1 ();
  spindle_rate_encoder_if #(.CNT_W(16)) if2 ();
  spindle_rate_encoder_if #(.CNT_W(4))  if3 ();

  spindle_rate_encoder u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  spindle_rate_encoder #(.TICK_HZ(1000)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  spindle_rate_encoder #(.TICK_HZ(1000), .REFRACT_TICKS(3)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  spindle_rate_encoder #(.TICK_HZ(1000), .CNT_W(4)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  typedef struct {
    logic [31:0] w;
    logic [16:0] q;
    logic        s;
  } vec_t;

  typedef struct {
    logic [16:0] q;
    logic        s;
  } exp_t;

  vec_t tbl[13];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic set_rv(input int k, input logic [31:0] w, input logic v);
    case (k)
      0: begin if0.rate_in = w; if0.rate_valid = v; end
      1: begin if1.rate_in = w; if1.rate_valid = v; end
      2: begin if2.rate_in = w; if2.rate_valid = v; end
      default: begin if3.rate_in = w; if3.rate_valid = v; end
    endcase
  endtask

  task automatic set_run(input int k, input logic en, input logic tk);
    case (k)
      0: begin if0.enable = en; if0.tick_en = tk; end
      1: begin if1.enable = en; if1.tick_en = tk; end
      2: begin if2.enable = en; if2.tick_en = tk; end
      default: begin if3.enable = en; if3.tick_en = tk; end
    endcase
  endtask

  // One-cycle rate strobe; returns at the negedge after rate_q has taken the new value.
  task automatic load(input int k, input logic [31:0] w);
    @(posedge clk); #1;
    set_rv(k, w, 1'b1);
    @(posedge clk); #1;
    set_rv(k, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard for if0: output due two edges after each accepted strobe.
  logic v1, v2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= if0.rate_valid;
      v2 <= v1;
    end
  end

  always @(negedge clk) begin
    if (v2) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL conv_sb: output with empty scoreboard, got %0d", if0.rate_q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("conv_rate_q", 32'(if0.rate_q), 32'(e.q));
        chk("conv_sat", 32'(if0.sat), 32'(e.s));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int spikes;
    tbl[0]  = '{32'h437A_0000, 17'd250,    1'b0};
    tbl[1]  = '{32'hC0A0_0000, 17'd0,      1'b0};
    tbl[2]  = '{32'h7FC0_0000, 17'd0,      1'b0};
    tbl[3]  = '{32'h3F00_0000, 17'd0,      1'b0};
    tbl[4]  = '{32'h3F80_0000, 17'd1,      1'b0};
    tbl[5]  = '{32'h4030_0000, 17'd2,      1'b0};
    tbl[6]  = '{32'h477F_FF00, 17'd65535,  1'b0};
    tbl[7]  = '{FP_100K,       17'd100000, 1'b0};
    tbl[8]  = '{32'h47C3_5080, 17'd100000, 1'b1};
    tbl[9]  = '{32'h4843_5000, 17'd100000, 1'b1};
    tbl[10] = '{32'h7F80_0000, 17'd100000, 1'b1};
    tbl[11] = '{32'hFF80_0000, 17'd0,      1'b1};
    tbl[12] = '{32'h0000_0000, 17'd0,      1'b1};

    for (int k = 0; k < 4; k++) begin
      set_rv(k, 32'h0, 1'b0);
      set_run(k, 1'b0, 1'b0);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rate_q", 32'(if0.rate_q), 0);
    chk("rst_sat", 32'(if0.sat), 0);
    chk("rst_spike", 32'(if1.spike), 0);
    chk("rst_count", 32'(if1.spike_count), 0);
    chk("rst_busy", 32'(if2.busy_refract), 0);
    reset = 1'b0;

    // Back-to-back conversion table through the scoreboard
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      set_rv(0, tbl[i].w, 1'b1);
      sb.push_back('{tbl[i].q, tbl[i].s});
    end
    @(posedge clk); #1;
    set_rv(0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("last_wins", 32'(if0.rate_q), 32'(tbl[12].q));

    // Zero-rate inputs never fire
    load(1, 32'hC0A0_0000);
    chk("neg_rate_q", 32'(if1.rate_q), 0);
    load(1, 32'h7FC0_0000);
    chk("nan_rate_q", 32'(if1.rate_q), 0);
    load(1, 32'h3F00_0000);
    chk("half_rate_q", 32'(if1.rate_q), 0);
    set_run(1, 1'b1, 1'b1);
    spikes = 0;
    repeat (10000) begin
      @(negedge clk);
      spikes += int'(if1.spike);
    end
    chk("zero_spikes", 32'(spikes), 0);
    chk("zero_count", 32'(if1.spike_count), 0);
    chk("zero_sat", 32'(if1.sat), 0);
    set_run(1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // 250 pps at 1 kHz: every fourth tick
    load(1, 32'h437A_0000);
    chk("r250_rate_q", 32'(if1.rate_q), 250);
    set_run(1, 1'b1, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("r250_spike", 32'(if1.spike), 32'(k % 4 == 0));
    end
    chk("r250_count", 32'(if1.spike_count), 25);

    // Drop enable at acc=500, restart from zero
    repeat (6) @(posedge clk);
    @(negedge clk);
    set_run(1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("en_drop_count", 32'(if1.spike_count), 26);
    chk("en_drop_spike", 32'(if1.spike), 0);
    set_run(1, 1'b1, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("restart_spike", 32'(if1.spike), 32'(k == 4));
    end
    chk("restart_count", 32'(if1.spike_count), 27);
    set_run(1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Over TICK_HZ clamps and fires every tick
    load(1, 32'h44BB_8000);
    chk("r1500_rate_q", 32'(if1.rate_q), 1000);
    chk("r1500_sat", 32'(if1.sat), 1);
    set_run(1, 1'b1, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("r1500_spike", 32'(if1.spike), 1);
    end
    chk("r1500_count", 32'(if1.spike_count), 32);
    set_run(1, 1'b0, 1'b0);

    // Refractory: fire, then three frozen ticks
    load(2, 32'h447A_0000);
    set_run(2, 1'b1, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("refr_spike", 32'(if2.spike), 32'(k % 4 == 1));
      chk("refr_busy", 32'(if2.busy_refract), 32'(k % 4 != 0));
    end

    // Async reset while in REFRACT
    reset = 1'b1;
    #1;
    chk("arst_spike", 32'(if2.spike), 0);
    chk("arst_count", 32'(if2.spike_count), 0);
    chk("arst_rate_q", 32'(if2.rate_q), 0);
    chk("arst_busy", 32'(if2.busy_refract), 0);
    chk("arst_sat1", 32'(if1.sat), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_spike", 32'(if2.spike), 0);
    end
    set_run(2, 1'b0, 1'b0);

    // 4-bit counter wraps after 16 spikes
    load(3, 32'h447A_0000);
    set_run(3, 1'b1, 1'b1);
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("wrap_count15", 32'(if3.spike_count), 15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wrap_count17", 32'(if3.spike_count), 1);
    set_run(3, 1'b0, 1'b0);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spindle_rate_encoder.md
Name: spindle_rate_encoder

Overview:
- Converts a spindle afferent firing-rate word (IEEE-754 single, pulses/s, e.g. Ia_muscle or II_muscle) into a spike train.
- Uses a phase-accumulator integrate-and-fire scheme with an optional refractory period.
- Sits downstream of the spindle model. It consumes the rate words the spindle produces and drives spike-based neuron and synapse blocks.
- One instance per afferent channel.

Parameters:
- TICK_HZ, 1000000, tick rate of tick_en in Hz; also the accumulator threshold.
- MAX_RATE, 100000, clamp ceiling for the converted rate, in pps.
- REFRACT_TICKS, 0, ticks after each spike during which accumulation is frozen (0 = none).
- CNT_W, 16, width of spike_count.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high.
- enable, input, 1, run control; low forces IDLE.
- rate_in, input, 32, IEEE-754 single rate in pps.
- rate_valid, input, 1, one-cycle strobe qualifying rate_in (pulses once per spindle 3-cycle update).
- tick_en, input, 1, time-base strobe at TICK_HZ.
- spike, output, 1, one-cycle spike pulse.
- spike_count, output, CNT_W, running spike count; wraps.
- rate_q, output, 17, converted and clamped integer rate in use.
- sat, output, 1, sticky; set when the requested rate exceeds MAX_RATE or TICK_HZ.
- busy_refract, output, 1, high while in REFRACT.

Behaviour:
- Reset values: spike=0, spike_count=0, rate_q=0, sat=0, busy_refract=0, accumulator=0, state=IDLE. Both pipeline registers are cleared.
- Conversion is a 2-stage pipeline.
  - Stage 1, registered on rate_valid: decode sign, exp and mantissa, e = exp-127.
    - sign=1 or exp<127 → 0.
    - exp=255 with mantissa≠0 (NaN) → 0.
    - exp=255 with mantissa=0 and sign=0 (+inf) → MAX_RATE, set sat.
    - e≥17 → MAX_RATE, set sat.
    - Otherwise value = {1,mantissa} >> (23-e), truncated.
  - Stage 2: clamp to min(value, MAX_RATE, TICK_HZ). Set sat if clamping occurred.
- rate_q is updated exactly 2 clk cycles after rate_valid.
- Back-to-back rate_valid is allowed: every sample passes through, and the last one wins.
- Conversion runs regardless of enable.
- sat clears only on reset.
- State machine: IDLE, RUN, REFRACT.
  - IDLE: accumulator held at 0. Go to RUN when enable=1 (next cycle).
  - RUN: on tick_en, acc_next = acc + rate_q.
    - If acc_next ≥ TICK_HZ: spike=1 for that cycle, acc ← acc_next - TICK_HZ, spike_count+1.
    - If REFRACT_TICKS>0, go to REFRACT with refract_cnt=REFRACT_TICKS.
    - Otherwise acc ← acc_next.
  - REFRACT: on each tick_en, decrement refract_cnt. The accumulator is frozen and no spike is issued. When the count reaches 1 on a tick, go to RUN; accumulation resumes on the next tick.
  - enable=0 in any state → IDLE next cycle; accumulator and refract_cnt cleared; spike_count retained.
- At most one spike per tick. The clamp to TICK_HZ guarantees the residual accumulator stays below TICK_HZ.
- spike is registered: it is asserted in the cycle after the tick_en cycle that crossed threshold, and deasserted otherwise.
- A rate_q change mid-phase takes effect on the next tick. The accumulator is not reset.
- spike_count wraps from 2^CNT_W-1 to 0 with no flag.
- Accumulator width is 32 bits unsigned. Overflow is impossible because acc < TICK_HZ and rate_q ≤ TICK_HZ.
- rate_valid and tick_en in the same cycle: the tick uses the old rate_q.
- Asynchronous reset mid-operation clears everything immediately. No spike is issued in the reset-release cycle.

Decomposition:
- Shared package holds:
  - IEEE constants: bias 127, exponent all-ones 255, 32'h47C3_5000 (100000.0).
  - Default TICK_HZ.
  - State encoding type (IDLE=0, RUN=1, REFRACT=2).
- One natural sub-module, float_to_uint_clamp: the two-stage float→integer conversion with clamp and saturation flag. It is reusable for other float-rate consumers.

Test Plan:
- Rate 250.0 (32'h437A_0000), TICK_HZ=1000, tick_en every cycle, enable=1 → rate_q=250; spikes on ticks 4, 8, 12…; spike_count=25 after 100 ticks.
- Rate -5.0 (32'hC0A0_0000), then NaN (32'h7FC0_0000), then 0.5 (32'h3F00_0000) → rate_q=0 for each; no spikes over 10000 ticks; sat stays 0.
- Rate 200000.0 (32'h4843_5000), default parameters → rate_q=100000, sat=1.
  - Then TICK_HZ=1000 with rate 1500.0 → rate_q=1000; one spike every tick.
- REFRACT_TICKS=3, TICK_HZ=1000, rate 1000.0 → a spike every 4th tick; busy_refract high for 3 ticks after each spike.
- Rate 250.0 running, enable dropped after tick 6 (acc=500), re-raised → accumulator restarts at 0; next spike 4 ticks after re-entering RUN; spike_count retained.
- CNT_W=4, 17 spikes → spike_count wraps to 1.
- Assert reset mid-REFRACT → all outputs 0 in the same cycle; state=IDLE.
